// File: rtl/sprite_cmd_scheduler_if.sv
// Host-side command bus of the sprite command scheduler: command writes,
// commit requests and the status flags returned to the host.
interface sprite_cmd_scheduler_if;
  logic        host_write;
  logic [31:0] host_writedata;
  logic        host_commit;
  logic        host_full;
  logic        commit_busy;
  logic        commit_done;

  modport master (
    output host_write, host_writedata, host_commit,
    input  host_full, commit_busy, commit_done
  );

  modport slave (
    input  host_write, host_writedata, host_commit,
    output host_full, commit_busy, commit_done
  );
endinterface

// File: rtl/sprite_cmd_scheduler.sv
// Queues host display commands and broadcasts them one per cycle, then on commit
// flushes the queued words and toggles every component's buffer during vblank.
module sprite_cmd_scheduler #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [5:0] COMP_LO    = 6'd1,
  parameter logic [5:0] COMP_HI    = 6'd12,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_TOTAL    = 525
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sprite_cmd_scheduler_if.slave host,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  output logic [31:0]          cmd_writedata,
  output logic                 front_buf,
  output logic [15:0]          frame_count,
  output logic                 overflow
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW-1:0]  DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [9:0]     VB_FIRST = 10'(V_ACTIVE);
  localparam logic [9:0]     VB_LAST  = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_WAIT_VB, S_TOGGLE} state_t;

  state_t        state_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] flush_cnt_q;
  logic          issue_vld_q;
  logic [31:0]   issue_word_q;
  logic [5:0]    comp_id_q;
  logic [31:0]   cmd_q;
  logic          front_buf_q;
  logic [15:0]   frame_count_q;
  logic          overflow_q;
  logic          busy_q;
  logic          done_q;

  logic full;
  logic reserved;
  logic push;
  logic pop;
  logic commit_accept;
  logic unused_ok;

  // Component 0 and the toggle opcode belong to the scheduler, so host words using them are dropped.
  assign full          = (count_q == DEPTH);
  assign reserved      = (host.host_writedata[31:26] == 6'd0) || (host.host_writedata[20:17] == 4'hF);
  assign push          = host.host_write && !full && !reserved;
  assign commit_accept = host.host_commit && !busy_q && (state_q == S_RUN);
  assign pop           = ((state_q == S_RUN) && !commit_accept && (count_q != '0))
                       || ((state_q == S_FLUSH) && (flush_cnt_q != '0));

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host.host_writedata;
    end
  end

  // Popped words pass through one staging register before reaching the broadcast bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      issue_vld_q  <= 1'b0;
      issue_word_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      issue_vld_q  <= pop;
      issue_word_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      flush_cnt_q   <= '0;
      comp_id_q     <= COMP_LO;
      cmd_q         <= '0;
      front_buf_q   <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (host.host_write && full) begin
        overflow_q <= 1'b1;
      end
      cmd_q <= issue_vld_q ? {issue_word_q[31:14], ~front_buf_q, issue_word_q[12:0]} : 32'h0;
      case (state_q)
        S_RUN: begin
          if (commit_accept) begin
            flush_cnt_q <= count_q + CW'(push);
            busy_q      <= 1'b1;
            state_q     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - CW'(1);
          end
          if (flush_cnt_q <= CW'(1)) begin
            state_q <= S_WAIT_VB;
          end
        end
        S_WAIT_VB: begin
          // The last line of the frame is too late to finish all toggles before scan-out.
          if ((vcount >= VB_FIRST) && (vcount < VB_LAST)) begin
            comp_id_q <= COMP_LO;
            state_q   <= S_TOGGLE;
          end
        end
        S_TOGGLE: begin
          cmd_q <= {comp_id_q, 5'd0, 4'hF, 3'd0, ~front_buf_q, 13'd0};
          if (comp_id_q == COMP_HI) begin
            front_buf_q   <= ~front_buf_q;
            frame_count_q <= frame_count_q + 16'd1;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_RUN;
          end else begin
            comp_id_q <= comp_id_q + 6'd1;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign cmd_writedata    = cmd_q;
  assign front_buf        = front_buf_q;
  assign frame_count      = frame_count_q;
  assign overflow         = overflow_q;
  assign host.host_full   = full;
  assign host.commit_busy = busy_q;
  assign host.commit_done = done_q;

  assign unused_ok = ^{hcount, issue_word_q[13]};

endmodule

// File: doc/sprite_cmd_scheduler.md
SPRITE_CMD_SCHEDULER -- requirements
Module: sprite_cmd_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, command FIFO entries (power of two).
REQ-002 SHALL have parameter COMP_LO, default 6'd1, lowest display component ID receiving buffer toggles.
REQ-003 SHALL have parameter COMP_HI, default 6'd12, highest display component ID receiving buffer toggles.
REQ-004 SHALL have parameter V_ACTIVE, default 480, first vblank line.
REQ-005 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-006 SHALL have one clock and asynchronous active-low reset: clk  in  1  system clock; reset_n  in  1  async active-low reset.
REQ-007 SHALL have host_write  in  1  host command strobe.
REQ-008 SHALL have host_writedata  in  32  host command word (display command format).
REQ-009 SHALL have host_commit  in  1  single-cycle request to present the current back buffer.
REQ-010 SHALL have hcount, vcount  in  10 each  raster position.
REQ-011 SHALL have cmd_writedata  out  32  registered command word broadcast to all display components.
REQ-012 SHALL have host_full  out  1  FIFO full; commit_busy  out  1  commit pending or in progress; commit_done  out  1  one-cycle completion pulse.
REQ-013 SHALL have front_buf  out  1  currently displayed buffer; frame_count  out  16  completed commits; overflow  out  1  sticky dropped-write flag.

Function
REQ-014 SHALL treat cmd_writedata == 32'h0 (component 0) as NOP and drive NOP every cycle no command is issued.
REQ-015 SHALL push host_writedata when host_write=1 and FIFO not full; a write while full SHALL be dropped and set overflow.
REQ-016 SHALL discard, without queuing, host words with [31:26]==0 or [20:17]==4'hF (reserved for the scheduler).
REQ-017 SHALL issue queued words as {word[31:14], ~front_buf, word[12:0]} (bit 13 forced to back buffer), one per cycle, in FIFO order.
REQ-018 SHALL make a word written to an empty FIFO in S_RUN appear on cmd_writedata two edges after the write edge, valid exactly one cycle; back-to-back writes SHALL produce back-to-back outputs.
REQ-019 SHALL implement states S_RUN, S_FLUSH, S_WAIT_VB, S_TOGGLE.
REQ-020 In S_RUN, SHALL drain FIFO freely; on host_commit SHALL latch flush_cnt = FIFO occupancy including a same-cycle accepted write, set commit_busy, go S_FLUSH.
REQ-021 In S_FLUSH, SHALL issue exactly flush_cnt words, then go S_WAIT_VB; words written after the commit SHALL stay queued.
REQ-022 In S_WAIT_VB, SHALL go S_TOGGLE on the first cycle with V_ACTIVE <= vcount < V_TOTAL-1; vcount == V_TOTAL-1 SHALL not start a toggle.
REQ-023 In S_TOGGLE, SHALL issue {id, 5'd0, 4'hF, 3'd0, ~front_buf, 13'd0} for id = COMP_LO..COMP_HI, one per consecutive cycle.
REQ-024 After the COMP_HI word SHALL invert front_buf, increment frame_count (wrap 16'hFFFF->0), pulse commit_done, clear commit_busy, return to S_RUN.
REQ-025 SHALL ignore host_commit while commit_busy=1.
REQ-026 SHALL keep accepting host writes in every state; FIFO simultaneous push and pop SHALL keep occupancy unchanged.
REQ-027 host_full SHALL be combinational from occupancy == FIFO_DEPTH.

Reset
REQ-028 On reset_n=0, SHALL asynchronously set: state S_RUN, FIFO empty, cmd_writedata 0, front_buf 0, frame_count 0, overflow 0, commit_busy 0, commit_done 0, host_full 0.
REQ-029 Reset mid-flush or mid-toggle SHALL abandon the sequence; no further toggle words issued.

Verification
REQ-030 Write 32'h2402_8064 in S_RUN, front_buf=0 -> cmd_writedata 32'h2402_A064 for one cycle two edges later, then 0.
REQ-031 Write 3 words, commit, write 2 more, vcount=100 -> exactly 3 issued, S_WAIT_VB holds; vcount=480 -> 12 toggle words for IDs 1..12 (ID 9: 32'h241E_2000), front_buf=1, frame_count=1, then 2 remaining words with bit 13 = 0.
REQ-032 Fill 16 words with output stalled by S_WAIT_VB, 17th write -> host_full=1, 17th dropped, overflow=1 sticky.
REQ-033 Commit with FIFO empty at vcount=524 -> no toggle until next frame's vcount=480; second commit pulse while busy -> ignored, frame_count +1 only.
REQ-034 Assert reset_n=0 during the 5th toggle word -> cmd_writedata 0 immediately, front_buf 0, no further toggle words after release.
